// File: rtl/rapid_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and pointer sizing.
package rapid_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_e;

   // A single channel still needs a 1-bit pointer/index so ports never collapse to zero width.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational requester pick: one-hot grant plus index of the winning channel.
// MEM_ARB_FIXED_PRIO_EN selects lowest-index-wins; default is round-robin from ptr.
module rr_pick
   import rapid_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int PTR_W   = ptr_width(N_PORTS)
) (
   input  logic [N_PORTS-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [N_PORTS-1:0] grant,
   output logic [PTR_W-1:0]   idx,
   output logic               any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int c = 0; c < N_PORTS; c++) begin
         if (!any && valid[c]) begin
            grant[c] = 1'b1;
            idx      = PTR_W'(c);
            any      = 1'b1;
         end
      end
   end
`else
   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      // Walk channels starting at ptr, wrapping, and keep the first valid one.
      for (int k = 0; k < N_PORTS; k++) begin
         c = (int'(ptr) + k) % N_PORTS;
         if (!any && valid[c]) begin
            grant[c] = 1'b1;
            idx      = PTR_W'(c);
            any      = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto a single memory-controller port, one transaction outstanding.
// Build option MEM_ARB_FIXED_PRIO_EN switches the pick to fixed priority (channel 0 highest).
//
// state     | meaning
// ARB_IDLE  | waiting for a requester; grant and latch payload on the same cycle
// ARB_ISSUE | o_mem_valid held with latched payload until controller accepts
// ARB_WAIT  | request accepted, waiting for controller response
// ARB_RESP  | one-cycle response pulse to owner, pointer advances past owner
module mem_port_arbiter
   import rapid_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [N_PORTS-1:0]        i_req_valid,
   output logic [N_PORTS-1:0]        o_req_ready,
   input  logic [N_PORTS-1:0]        i_req_we,
   input  logic [N_PORTS*ADDR_W-1:0] i_req_addr,
   input  logic [N_PORTS*DATA_W-1:0] i_req_wdata,
   input  logic [N_PORTS*BE_W-1:0]   i_req_be,
   output logic [N_PORTS-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]         o_rsp_rdata,
   output logic                      o_mem_valid,
   input  logic                      i_mem_ready,
   output logic                      o_mem_we,
   output logic [ADDR_W-1:0]         o_mem_addr,
   output logic [DATA_W-1:0]         o_mem_wdata,
   output logic [BE_W-1:0]           o_mem_be,
   input  logic                      i_mem_rsp_valid,
   input  logic [DATA_W-1:0]         i_mem_rsp_rdata
);

   localparam int PTR_W = ptr_width(N_PORTS);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d, owner_q, pick_idx;
   logic [N_PORTS-1:0] pick_grant, owner_onehot, rsp_valid_q;
   logic               pick_any, accept, rsp_take;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q, rsp_rdata_q;
   logic [BE_W-1:0]    mem_be_q;

   rr_pick #(
      .N_PORTS (N_PORTS),
      .PTR_W   (PTR_W)
   ) u_pick (
      .valid (i_req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      owner_onehot = '0;
      for (int c = 0; c < N_PORTS; c++) begin
         owner_onehot[c] = (owner_q == PTR_W'(c));
      end
   end

   // With one channel this always yields 0, so the pointer stays constant.
   assign ptr_d = (int'(owner_q) == N_PORTS - 1) ? '0 : owner_q + PTR_W'(1);

   always_comb begin
      state_d     = state_q;
      o_req_ready = '0;
      o_mem_valid = 1'b0;
      accept      = 1'b0;
      rsp_take    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any && !i_reset) begin
               o_req_ready = pick_grant;
               accept      = 1'b1;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            o_mem_valid = 1'b1;
            if (i_mem_ready) begin
               rsp_take = i_mem_rsp_valid;
               state_d  = i_mem_rsp_valid ? ARB_RESP : ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (i_mem_rsp_valid) begin
               rsp_take = 1'b1;
               state_d  = ARB_RESP;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q     <= pick_idx;
            mem_we_q    <= i_req_we[int'(pick_idx)];
            mem_addr_q  <= i_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            mem_wdata_q <= i_req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            mem_be_q    <= i_req_be[int'(pick_idx)*BE_W +: BE_W];
         end
         // Response pulse is registered so it lines up exactly with the RESP state.
         if (rsp_take) begin
            rsp_valid_q <= owner_onehot;
            rsp_rdata_q <= i_mem_rsp_rdata;
         end else begin
            rsp_valid_q <= '0;
         end
         if (state_q == ARB_RESP) begin
            ptr_q <= ptr_d;
         end
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions flow grant -> issue -> response.
module tb_mem_port_arbiter;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;

   typedef struct {
      int          ch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          gcyc;
      int          lat;
   } txn_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NP-1:0]    req_valid = '0;
   logic [NP-1:0]    req_ready;
   logic [NP-1:0]    req_we = '0;
   logic [NP*AW-1:0] req_addr = '0;
   logic [NP*DW-1:0] req_wdata = '0;
   logic [NP*BW-1:0] req_be = '0;
   logic [NP-1:0]    rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             mem_valid;
   logic             mem_ready = 1'b0;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [BW-1:0]    mem_be;
   logic             mem_rsp_valid = 1'b0;
   logic [DW-1:0]    mem_rsp_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mem_stall = 0;
   int mem_lat = 2;

   txn_t chq[NP][$];
   txn_t q_grant[$];
   txn_t q_issue[$];
   txn_t q_rsp[$];

   mem_port_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_we        (req_we),
      .i_req_addr      (req_addr),
      .i_req_wdata     (req_wdata),
      .i_req_be        (req_be),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_rdata     (rsp_rdata),
      .o_mem_valid     (mem_valid),
      .i_mem_ready     (mem_ready),
      .o_mem_we        (mem_we),
      .o_mem_addr      (mem_addr),
      .o_mem_wdata     (mem_wdata),
      .o_mem_be        (mem_be),
      .i_mem_rsp_valid (mem_rsp_valid),
      .i_mem_rsp_rdata (mem_rsp_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h0100_0193) ^ 32'h5A5A_0000);
   endfunction

   function automatic txn_t mk(input int ch, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
      txn_t t;
      t.ch = ch; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
      t.rdata = mem_model(addr); t.gcyc = 0; t.lat = 0;
      return t;
   endfunction

   function automatic int pending();
      return q_grant.size() + q_issue.size() + q_rsp.size() + chq[0].size() + chq[1].size();
   endfunction

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (pending() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, pending(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
      chk({tag, "_mem_valid"}, mem_valid, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_be"}, mem_be, 0);
   endtask

   // Requesters: hold valid+payload until accepted, then present the next queued request.
   initial begin : requesters
      logic [NP-1:0] rdy_s;
      forever begin
         @(negedge clk);
         rdy_s = req_ready;
         @(posedge clk);
         #1;
         for (int c = 0; c < NP; c++) begin
            if (rdy_s[c] && chq[c].size() > 0) void'(chq[c].pop_front());
            if (chq[c].size() > 0) begin
               req_valid[c]            = 1'b1;
               req_we[c]               = chq[c][0].we;
               req_addr[c*AW +: AW]    = chq[c][0].addr;
               req_wdata[c*DW +: DW]   = chq[c][0].wdata;
               req_be[c*BW +: BW]      = chq[c][0].be;
            end else begin
               req_valid[c] = 1'b0;
            end
         end
      end
   end

   initial begin : grant_monitor
      txn_t t;
      forever begin
         @(negedge clk);
         if (req_ready != 0) begin
            chk("grant_onehot", $onehot(req_ready), 1);
            if (q_grant.size() == 0) begin
               chk("grant_unexpected", req_ready, 0);
            end else begin
               t = q_grant.pop_front();
               chk("grant_ch", req_ready, 64'(1 << t.ch));
               t.gcyc = cyc;
               q_issue.push_back(t);
            end
         end
      end
   end

   initial begin : rsp_monitor
      txn_t t;
      forever begin
         @(negedge clk);
         if (rsp_valid != 0) begin
            if (q_rsp.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               t = q_rsp.pop_front();
               chk("rsp_vec", rsp_valid, 64'(1 << t.ch));
               chk("rsp_rdata", rsp_rdata, t.rdata);
               chk("rsp_latency", cyc - t.gcyc, t.lat);
            end
         end
      end
   end

   // Memory controller: optional stall, then accept; response mem_lat cycles after acceptance.
   initial begin : responder
      txn_t t;
      int stalled;
      logic [31:0] rd;
      stalled = 0;
      forever begin
         @(negedge clk);
         if (mem_valid) begin
            if (stalled < mem_stall) begin
               chk("bp_no_grant", req_ready, 0);
               if (q_issue.size() > 0) begin
                  chk("bp_addr", mem_addr, q_issue[0].addr);
                  chk("bp_wdata", mem_wdata, q_issue[0].wdata);
                  chk("bp_be", mem_be, q_issue[0].be);
               end
               stalled++;
            end else begin
               stalled = 0;
               if (q_issue.size() == 0) begin
                  chk("mem_unexpected", mem_valid, 0);
               end else begin
                  t = q_issue.pop_front();
                  chk("mem_we", mem_we, t.we);
                  chk("mem_addr", mem_addr, t.addr);
                  chk("mem_wdata", mem_wdata, t.wdata);
                  chk("mem_be", mem_be, t.be);
                  t.lat = 2 + mem_stall + mem_lat;
                  q_rsp.push_back(t);
               end
               rd = mem_model(mem_addr);
               mem_ready = 1'b1;
               if (mem_lat == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_rdata = rd;
               end
               @(posedge clk);
               #1;
               mem_ready     = 1'b0;
               mem_rsp_valid = 1'b0;
               if (mem_lat > 0) begin
                  repeat (mem_lat - 1) @(posedge clk);
                  #1;
                  mem_rsp_valid = 1'b1;
                  mem_rsp_rdata = rd;
                  @(posedge clk);
                  #1;
                  mem_rsp_valid = 1'b0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      txn_t a0, a1, b0, b1;
      int n;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Single read on ch1, response two cycles after acceptance.
      mem_stall = 0; mem_lat = 2;
      a1 = mk(1, 1'b0, 32'h100, 32'h0, 4'hF);
      chq[1].push_back(a1); q_grant.push_back(a1);
      wait_drain("t1_drain", 100);

      // Contention with both channels continuously valid.
      a0 = mk(0, 1'b0, 32'h10, 32'h0, 4'hF);
      b0 = mk(0, 1'b1, 32'h14, 32'h1111_2222, 4'hF);
      a1 = mk(1, 1'b0, 32'h20, 32'h0, 4'hF);
      b1 = mk(1, 1'b1, 32'h24, 32'h3333_4444, 4'h5);
      chq[0].push_back(a0); chq[0].push_back(b0);
      chq[1].push_back(a1); chq[1].push_back(b1);
`ifdef MEM_ARB_FIXED_PRIO_EN
      q_grant.push_back(a0); q_grant.push_back(b0); q_grant.push_back(a1); q_grant.push_back(b1);
`else
      q_grant.push_back(a0); q_grant.push_back(a1); q_grant.push_back(b0); q_grant.push_back(b1);
`endif
      wait_drain("t2_drain", 200);

      // Backpressure: controller stalls 5 cycles per request while the other channel waits.
      mem_stall = 5; mem_lat = 1;
      a0 = mk(0, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b1100);
      a1 = mk(1, 1'b0, 32'h204, 32'h0, 4'hF);
      chq[0].push_back(a0); chq[1].push_back(a1);
      q_grant.push_back(a0); q_grant.push_back(a1);
      wait_drain("t3_drain", 200);

      // Write on ch0 with partial byte enables.
      mem_stall = 0; mem_lat = 3;
      a1 = mk(1, 1'b0, 32'h50, 32'h0, 4'hF);
      chq[1].push_back(a1); q_grant.push_back(a1);
      wait_drain("t6a_drain", 100);
      a0 = mk(0, 1'b1, 32'h40, 32'h0000_1234, 4'b0011);
      chq[0].push_back(a0); q_grant.push_back(a0);
      wait_drain("t6_drain", 100);

      // Zero-latency memory: ready and response together, 3-cycle transaction.
      mem_stall = 0; mem_lat = 0;
      a0 = mk(0, 1'b0, 32'h80, 32'h0, 4'hF);
      chq[0].push_back(a0); q_grant.push_back(a0);
      wait_drain("t4_drain", 100);

      // Reset while waiting on a long read; the late response must be dropped.
      mem_stall = 0; mem_lat = 6;
      a1 = mk(1, 1'b0, 32'h300, 32'h0, 4'hF);
      chq[1].push_back(a1); q_grant.push_back(a1);
      n = 0;
      while (q_grant.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_grant_seen", q_grant.size(), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      q_rsp.delete();
      @(negedge clk);
      check_zero("t5_in_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      check_zero("t5_after_late_rsp");

      // Pointer must be back at 0: ch0 wins over ch1 after the reset.
      mem_lat = 1;
      a0 = mk(0, 1'b0, 32'h400, 32'h0, 4'hF);
      a1 = mk(1, 1'b0, 32'h404, 32'h0, 4'hF);
      chq[0].push_back(a0); chq[1].push_back(a1);
      q_grant.push_back(a0); q_grant.push_back(a1);
      wait_drain("t5_ptr_drain", 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
